// File: rtl/adder_operand_loader_if.sv
// Word-stream input and operand-set output of the 128-bit adder operand loader.
// master = word source / operand consumer side, slave = the loader itself.
interface adder_operand_loader_if #(
    parameter int WORD_W = 32,
    parameter int OPW    = 128
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_first;
    logic              in_cin;
    logic              in_ready;
    logic [OPW-1:0]    din_one;
    logic [OPW-1:0]    din_two;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic              sync_err;

    modport master (
        output in_data, in_valid, in_first, in_cin, out_ready,
        input  in_ready, din_one, din_two, cin, out_valid, sync_err
    );

    modport slave (
        input  in_data, in_valid, in_first, in_cin, out_ready,
        output in_ready, din_one, din_two, cin, out_valid, sync_err
    );
endinterface

// File: rtl/adder_operand_loader.sv
// Assembles operands A and B from a framed, LS-word-first word stream and
// holds them, with the carry-in, until the downstream adder takes the set.
module adder_operand_loader #(
    parameter int WORD_W = 32,
    parameter int OPW    = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adder_operand_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

    localparam int BEATS = OPW / WORD_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // A framed word 0 completes operand A outright when an operand is one word wide.
    localparam logic [CNT_W-1:0] CNT_AFTER_FIRST   = (BEATS > 1) ? CNT_W'(1) : '0;
    localparam state_t           STATE_AFTER_FIRST = (BEATS > 1) ? LOAD_A : LOAD_B;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign bus.in_ready = (state != HOLD);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; operand registers are reset too so outputs start at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= LOAD_A;
            cnt           <= '0;
            bus.din_one   <= '0;
            bus.din_two   <= '0;
            bus.cin       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.sync_err  <= 1'b0;
        end else begin
            bus.sync_err <= 1'b0;
            unique case (state)
                LOAD_A: begin
                    if (bus.in_valid) begin
                        if (bus.in_first) begin
                            // A frame start while mid-operand is a restart and a framing error.
                            bus.din_one[WORD_W-1:0] <= bus.in_data;
                            cnt                     <= CNT_AFTER_FIRST;
                            state                   <= STATE_AFTER_FIRST;
                            bus.sync_err            <= (cnt != '0);
                        end else if (cnt == '0) begin
                            bus.sync_err <= 1'b1;
                        end else begin
                            bus.din_one[cnt*WORD_W +: WORD_W] <= bus.in_data;
                            if (cnt == LAST_BEAT) begin
                                cnt   <= '0;
                                state <= LOAD_B;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                end

                LOAD_B: begin
                    if (bus.in_valid) begin
                        if (bus.in_first) begin
                            bus.din_one[WORD_W-1:0] <= bus.in_data;
                            cnt                     <= CNT_AFTER_FIRST;
                            state                   <= STATE_AFTER_FIRST;
                            bus.sync_err            <= 1'b1;
                        end else begin
                            bus.din_two[cnt*WORD_W +: WORD_W] <= bus.in_data;
                            if (cnt == LAST_BEAT) begin
                                bus.cin       <= bus.in_cin;
                                bus.out_valid <= 1'b1;
                                cnt           <= '0;
                                state         <= HOLD;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                end

                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= LOAD_A;
                    end
                end

                default: begin
                    state <= LOAD_A;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule
